// File: rtl/cook_control.sv
// rtl/cook_control.sv - microwave cook session FSM with magnetron PWM, timer control and completion beep
module cook_control #(
  parameter int PWR_W       = 2,
  parameter int PWM_PERIOD  = 16,
  parameter int BEEP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power_lvl,
  output logic             mag_on,
  output logic             timer_en,
  output logic             timer_clr,
  output logic             beep,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam int DW = CW + PWR_W + 1;
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             start_prev;   // start button was pressed last cycle
  logic             start_ev;
  logic             start_ok;
  logic             clr_req;
  logic             timer_clr_q;
  logic [CW-1:0]    pwm_cnt;
  logic [PWR_W-1:0] pwr_q;
  logic [BW-1:0]    beep_cnt;
  logic [DW-1:0]    duty;

  // start_prev resets as "pressed" so a button held through reset must be released first
  assign start_ev = ~startn & ~start_prev;
  assign start_ok = start_ev & door_closed & stopn & ~timer_done;

  // next-state selection; clear outranks stop/door, which outrank timer_done, which outranks start
  always_comb begin
    state_d = state_q;
    clr_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clearn) begin
          clr_req = 1'b1;
        end else if (start_ok) begin
          state_d = COOK;
        end
      end
      COOK: begin
        if (!clearn) begin
          state_d = IDLE;
          clr_req = 1'b1;
        end else if (!stopn || !door_closed) begin
          state_d = PAUSE;
        end else if (timer_done) begin
          state_d = DONE;
        end
      end
      PAUSE: begin
        if (!clearn) begin
          state_d = IDLE;
          clr_req = 1'b1;
        end else if (start_ok) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (!clearn || start_ev || !door_closed || beep_cnt == '0) begin
          state_d = IDLE;
          clr_req = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register, start edge history and registered timer clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_prev  <= 1'b1;
      timer_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_prev  <= ~startn;
      timer_clr_q <= clr_req;
    end
  end

  // PWM phase and power latch: restart on COOK entry, reload power only on period wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwr_q   <= '0;
    end else if (state_d == COOK && state_q != COOK) begin
      pwm_cnt <= '0;
      pwr_q   <= power_lvl;
    end else if (state_q == COOK) begin
      if (pwm_cnt == CW'(PWM_PERIOD - 1)) begin
        pwm_cnt <= '0;
        pwr_q   <= power_lvl;
      end else begin
        pwm_cnt <= pwm_cnt + CW'(1);
      end
    end
  end

  // beep length counter: loads on DONE entry, counts down to zero while in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      beep_cnt <= '0;
    end else if (state_d == DONE && state_q != DONE) begin
      beep_cnt <= BW'(BEEP_CYCLES - 1);
    end else if (state_q == DONE && beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BW'(1);
    end
  end

  // on-time per period; widened so the top level reaches a full PWM_PERIOD
  always_comb begin
    duty = ((DW'(pwr_q) + DW'(1)) * DW'(PWM_PERIOD)) >> PWR_W;
  end

  assign mag_on    = (state_q == COOK) && (DW'(pwm_cnt) < duty);
  assign timer_en  = (state_q == COOK);
  assign timer_clr = timer_clr_q;
  assign beep      = (state_q == DONE);
  assign busy      = (state_q == COOK) || (state_q == PAUSE);
  assign state     = state_q;

endmodule

// File: doc/cook_control.md
# cook_control

Clocked successor to the microwave's combinational set/reset logic. Owns the cook session state (idle, cooking, paused, done), generates a power-level PWM enable for the magnetron, drives the cook timer's enable and clear, and sounds a finite completion beep. It sits between the debounced front-panel inputs, the door switch and the countdown timer, and drives the magnetron and buzzer drivers.

## Interface
- PWR_W, 2: power-level select width; 2^PWR_W levels.
- PWM_PERIOD, 16: magnetron PWM period in clk cycles; must be a multiple of 2^PWR_W and at least 2^PWR_W.
- BEEP_CYCLES, 8: completion beep length in cycles; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- startn  in  1  start button, active low, already debounced.
- stopn  in  1  stop/pause button, active low.
- clearn  in  1  clear button, active low.
- door_closed  in  1  door switch; 1 = closed.
- timer_done  in  1  countdown timer expired, level.
- power_lvl  in  PWR_W  requested power level; 0 = lowest.
- mag_on  out  1  magnetron enable.
- timer_en  out  1  timer count enable.
- timer_clr  out  1  timer clear, single-cycle pulse.
- beep  out  1  buzzer enable.
- busy  out  1  high in COOK or PAUSE.
- state  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.

## Operation
- Start event: startn low this cycle and high in the previous cycle (registered start_prev). Holding start does not re-trigger.
- Per-cycle priority: clear > (stop or door open) > timer_done > start event.
- IDLE:
  - clearn low -> timer_clr.
  - start event with door_closed=1, stopn=1 and timer_done=0 -> COOK.
  - Otherwise stay in IDLE.
- COOK:
  - clearn low -> IDLE, with timer_clr.
  - stopn low or door_closed=0 -> PAUSE.
  - timer_done=1 -> DONE.
- PAUSE:
  - clearn low -> IDLE, with timer_clr.
  - start event with door_closed=1, stopn=1 and timer_done=0 -> COOK.
  - The timer value is retained because timer_clr is not pulsed.
- DONE:
  - beep_cnt loads BEEP_CYCLES-1 on entry and decrements each cycle.
  - Exit to IDLE with timer_clr when beep_cnt==0, or earlier on clearn low, a start event, or door_closed=0.
- Power latching:
  - On any entry into COOK: pwr_q <= power_lvl and pwm_cnt <= 0.
  - In COOK, pwm_cnt counts 0..PWM_PERIOD-1 and wraps. pwr_q reloads from power_lvl on the wrap.
  - pwm_cnt holds in all other states.
- Duty: duty = ((pwr_q+1) * PWM_PERIOD) >> PWR_W. Compute at width clog2(PWM_PERIOD)+PWR_W+1 so it cannot overflow. The top level gives duty = PWM_PERIOD, i.e. always on.
- Output decodes (from registered state and counters only; no combinational path from inputs):
  - mag_on = (state==COOK) && (pwm_cnt < duty).
  - timer_en = (state==COOK).
  - beep = (state==DONE).
  - busy = COOK or PAUSE.
- timer_clr is registered: high in the cycle after the triggering condition, for exactly one cycle per transition. It stays high continuously while clearn is held low in IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - mag_on=0, timer_en=0, timer_clr=0, beep=0, busy=0.
  - pwm_cnt=0, pwr_q=0, beep_cnt=0.
  - start_prev=1, so a start button held through reset does not fire.
- Latency: an input sampled on edge N changes state at edge N, and the outputs reflect it from edge N onward (one cycle after the input is applied).
- Door opens mid-COOK: mag_on and timer_en are low one cycle after door_closed falls. Safety-critical; no longer path is allowed.
- rst during COOK: mag_on=0 from the next edge.
- Simultaneous events resolve by priority:
  - timer_done and stop in the same cycle -> PAUSE.
  - clear and start in the same cycle -> IDLE.
- A start event with the door open is ignored and is not remembered.
- Resume from PAUSE restarts the PWM phase at pwm_cnt=0 with a freshly latched power level.

## Test plan
- Basic cook: reset, door_closed=1, power_lvl=1, pulse startn low 1 cycle -> state=1 next cycle; mag_on high 8 of every 16 cycles, starting at pwm_cnt=0; timer_en=1 continuously.
- Door interlock: during COOK drop door_closed -> state=2, mag_on=0, timer_en=0 after one cycle; close door with startn still held -> stays PAUSE; release and press start -> COOK.
- Completion: in COOK assert timer_done -> state=3, beep high exactly 8 cycles, then state=0 with timer_clr high for 1 cycle; assert clearn in DONE cycle 3 -> early exit to IDLE plus timer_clr.
- Priority: in COOK assert stopn=0 and timer_done=1 together -> PAUSE, not DONE; in PAUSE assert clearn=0 and startn falling together -> IDLE with timer_clr.
- Power levels: power_lvl 0/2/3 -> mag_on duty of 4/12/16 per 16 cycles; change power_lvl mid-period -> takes effect only after the pwm_cnt wrap.
- Reset: startn held low through rst release -> no COOK; rst asserted mid-COOK -> all outputs 0 next cycle.
